// File: rtl/sender_scheduler.sv
// -----------------------------------------------------------------------------
// sender_scheduler
//
// Sits in front of the serial packet sender. It arbitrates three 40-bit
// packet requesters round-robin, paces grants to at most one packet per tick
// frame at a fixed frame phase, generates the sender's audio-sample-request
// tick and mode, and counts loss events reported by the sender.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   en                  grant enable, sampled only at the WAIT->ARB decision
//   audio_enable        requested audio-sample-request mode (level)
//   req_valid[2:0]      per-requester packet pending
//   req_data0/1/2       requester packets (held stable while valid)
//   req_ready[2:0]      one-hot accept, only ever high during ARB
//   out_data[39:0]      packet to sender, holds its value between grants
//   out_valid           one-cycle packet strobe to sender
//   tick                high when the phase counter is at TICK_PERIOD-1
//   mode                audio mode, reloaded once per frame at TICK_PERIOD-2
//   sender_loss         sender data-loss flag
//   loss_count          saturating count of sender_loss rising edges
// -----------------------------------------------------------------------------
module sender_scheduler #(
  parameter int TICK_PERIOD  = 114,
  parameter int GRANT_OFFSET = 2,
  parameter int LOSS_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              audio_enable,
  input  logic [2:0]        req_valid,
  input  logic [39:0]       req_data0,
  input  logic [39:0]       req_data1,
  input  logic [39:0]       req_data2,
  output logic [2:0]        req_ready,
  output logic [39:0]       out_data,
  output logic              out_valid,
  output logic              tick,
  output logic              mode,
  input  logic              sender_loss,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int CNT_W = $clog2(TICK_PERIOD);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_PERIOD - 1);
  localparam logic [CNT_W-1:0] MODE_LOAD = CNT_W'(TICK_PERIOD - 2);
  localparam logic [CNT_W-1:0] ARB_PHASE = CNT_W'(GRANT_OFFSET - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Frame phase counter and tick/mode generation
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // Loading one cycle before the tick keeps mode stable across the tick.
    mode_d = (cnt_q == MODE_LOAD) ? audio_enable : mode_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);
  assign mode = mode_q;

  // ---------------------------------------------------------------------------
  // Round-robin winner search, starting at the requester after last_q
  // ---------------------------------------------------------------------------
  logic [1:0]  last_q, last_d;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [39:0] win_data;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    unique case (last_q)
      2'd0: begin
        if      (req_valid[1]) begin win_found = 1'b1; win_idx = 2'd1; end
        else if (req_valid[2]) begin win_found = 1'b1; win_idx = 2'd2; end
        else if (req_valid[0]) begin win_found = 1'b1; win_idx = 2'd0; end
      end
      2'd1: begin
        if      (req_valid[2]) begin win_found = 1'b1; win_idx = 2'd2; end
        else if (req_valid[0]) begin win_found = 1'b1; win_idx = 2'd0; end
        else if (req_valid[1]) begin win_found = 1'b1; win_idx = 2'd1; end
      end
      default: begin
        if      (req_valid[0]) begin win_found = 1'b1; win_idx = 2'd0; end
        else if (req_valid[1]) begin win_found = 1'b1; win_idx = 2'd1; end
        else if (req_valid[2]) begin win_found = 1'b1; win_idx = 2'd2; end
      end
    endcase
  end

  always_comb begin
    unique case (win_idx)
      2'd0:    win_data = req_data0;
      2'd1:    win_data = req_data1;
      default: win_data = req_data2;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [39:0] out_data_q, out_data_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    req_ready  = 3'b000;
    out_valid  = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        // Enter ARB together with the counter reaching the grant slot, so ARB
        // occupies phase GRANT_OFFSET-1 and ISSUE phase GRANT_OFFSET.
        if (en && (cnt_d == ARB_PHASE)) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_found) begin
          req_ready  = 3'b001 << win_idx;
          out_data_d = win_data;
          last_d     = win_idx;
          state_d    = ST_ISSUE;
        end else begin
          state_d    = ST_WAIT;
        end
      end
      ST_ISSUE: begin
        out_valid = 1'b1;
        state_d   = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      last_q     <= 2'd2;  // requester 0 wins the first search
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;

  // ---------------------------------------------------------------------------
  // Loss-event counter: rising edges of sender_loss, saturating at all-ones
  // ---------------------------------------------------------------------------
  logic              loss_prev_q;
  logic [LOSS_W-1:0] loss_count_q, loss_count_d;
  logic              loss_rise;

  always_comb begin
    loss_rise    = sender_loss & ~loss_prev_q;
    loss_count_d = loss_count_q;
    if (loss_rise && !(&loss_count_q)) loss_count_d = loss_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_prev_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      loss_prev_q  <= sender_loss;
      loss_count_q <= loss_count_d;
    end
  end

  assign loss_count = loss_count_q;

endmodule
